// File: rtl/boot_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : boot_fetch_buf
// Description : Single-line read buffer in front of a boot ROM; misses fill
//               the whole line with one incrementing burst.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_fetch_buf #(
    parameter int unsigned WID  = 64,
    parameter logic [2:0]  BLEN = 3'd3,
    parameter logic [7:0]  TMO  = 8'd255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           req_i,
    input  logic [17:0]    radr_i,
    input  logic           inv_i,
    output logic           rdy_o,
    output logic [WID-1:0] dat_o,
    output logic           err_o,
    output logic           cs_o,
    output logic           cyc_o,
    output logic           stb_o,
    output logic [2:0]     cti_o,
    output logic [17:0]    adr_o,
    input  logic           ack_i,
    input  logic [WID-1:0] dat_i
);

    localparam int unsigned c_WORDS = int'(BLEN) + 1;
    localparam int unsigned c_LOG   = $clog2(c_WORDS);
    localparam int unsigned c_IW    = (c_LOG > 0) ? c_LOG : 1;
    localparam int unsigned c_DEPTH = 1 << c_IW;
    localparam int unsigned c_OFF   = 3 + c_LOG;
    localparam int unsigned c_TAGW  = 18 - c_OFF;

    localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] c_CTI_INCR    = 3'b010;
    localparam logic [2:0] c_CTI_END     = 3'b111;
    localparam logic [2:0] c_CTI_FIRST   = (BLEN == 3'd0) ? c_CTI_CLASSIC : c_CTI_INCR;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_valid;
    logic              r_pend;
    logic [2:0]        r_beat;
    logic [7:0]        r_tmo;
    logic [c_TAGW-1:0] r_tag;
    logic [c_TAGW-1:0] r_ftag;
    logic [WID-1:0]    r_buf [c_DEPTH];
    logic              r_rdy;
    logic [WID-1:0]    r_dat;
    logic              r_err;
    logic              r_bus;
    logic [2:0]        r_cti;
    logic [17:0]       r_adr;

    logic [c_IW-1:0]   w_idx;
    logic [c_TAGW-1:0] w_tag;
    logic              w_hit;
    logic              w_last_ack;
    logic              w_timeout;
    logic              w_unused;

    generate
        if (c_LOG > 0) begin : g_idx
            assign w_idx = radr_i[c_OFF-1:3];
        end else begin : g_idx_single
            assign w_idx = 1'b0;
        end
    endgenerate

    assign w_tag      = radr_i[17:c_OFF];
    assign w_hit      = r_valid && (r_tag == w_tag) && (r_state == IDLE);
    assign w_last_ack = (r_state == FETCH) && ack_i && (r_beat == BLEN);
    assign w_timeout  = (r_state == FETCH) && !ack_i && (r_tmo == TMO - 8'd1);
    assign w_unused   = ^{radr_i[2:0], r_beat};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_i && !w_hit) w_state_nxt = FETCH;
            FETCH:   if (w_last_ack || w_timeout) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Line storage carries no reset; r_valid alone decides whether it is usable.
    always_ff @(posedge clk_i) begin
        if ((r_state == FETCH) && ack_i) begin
            r_buf[r_beat[c_IW-1:0]] <= dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_pend  <= 1'b0;
            r_beat  <= 3'd0;
            r_tmo   <= 8'd0;
            r_tag   <= '0;
            r_ftag  <= '0;
            r_rdy   <= 1'b0;
            r_dat   <= '0;
            r_err   <= 1'b0;
            r_bus   <= 1'b0;
            r_cti   <= c_CTI_CLASSIC;
            r_adr   <= 18'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_i && w_hit) begin
                        r_rdy <= 1'b1;
                        r_dat <= r_buf[w_idx];
                    end
                    if (inv_i) r_valid <= 1'b0;
                    if (req_i && !w_hit) begin
                        // The old line is overwritten beat by beat, so it stops being valid now.
                        r_valid <= 1'b0;
                        r_ftag  <= w_tag;
                        r_adr   <= {w_tag, {c_OFF{1'b0}}};
                        r_bus   <= 1'b1;
                        r_cti   <= c_CTI_FIRST;
                        r_beat  <= 3'd0;
                        r_tmo   <= 8'd0;
                        r_pend  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (inv_i) r_pend <= 1'b1;
                    if (ack_i) begin
                        r_tmo <= 8'd0;
                        if (r_beat == BLEN) begin
                            r_bus   <= 1'b0;
                            r_cti   <= c_CTI_CLASSIC;
                            r_tag   <= r_ftag;
                            r_valid <= !(r_pend || inv_i);
                            r_beat  <= 3'd0;
                            r_pend  <= 1'b0;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                            r_adr  <= r_adr + 18'd8;
                            r_cti  <= ((r_beat + 3'd1) == BLEN) ? c_CTI_END : c_CTI_INCR;
                        end
                    end else if (w_timeout) begin
                        r_bus   <= 1'b0;
                        r_cti   <= c_CTI_CLASSIC;
                        r_valid <= 1'b0;
                        r_err   <= 1'b1;
                        r_beat  <= 3'd0;
                        r_tmo   <= 8'd0;
                        r_pend  <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                DONE: begin
                    if (inv_i) r_valid <= 1'b0;
                end
                default: begin
                    r_bus <= 1'b0;
                end
            endcase
        end
    end

    assign rdy_o = r_rdy;
    assign dat_o = r_dat;
    assign err_o = r_err;
    assign cs_o  = r_bus;
    assign cyc_o = r_bus;
    assign stb_o = r_bus;
    assign cti_o = r_cti;
    assign adr_o = r_adr;

endmodule
`default_nettype wire

// File: tb/tb_boot_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_fetch_buf
// Description : Scoreboard bench for boot_fetch_buf acting as the boot ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_fetch_buf;

    logic        clk;
    logic        rst_i;
    logic        req_i;
    logic [17:0] radr_i;
    logic        inv_i;
    logic        rdy_o;
    logic [63:0] dat_o;
    logic        err_o;
    logic        cs_o;
    logic        cyc_o;
    logic        stb_o;
    logic [2:0]  cti_o;
    logic [17:0] adr_o;
    logic        ack_i;
    logic [63:0] dat_i;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [17:0] adr;
        logic [2:0]  cti;
    } beat_t;

    logic [63:0] exp_q [$];
    beat_t       bus_q [$];

    boot_fetch_buf dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .radr_i (radr_i),
        .inv_i  (inv_i),
        .rdy_o  (rdy_o),
        .dat_o  (dat_o),
        .err_o  (err_o),
        .cs_o   (cs_o),
        .cyc_o  (cyc_o),
        .stb_o  (stb_o),
        .cti_o  (cti_o),
        .adr_o  (adr_o),
        .ack_i  (ack_i),
        .dat_i  (dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rom(input logic [17:0] a);
        return {a[17:3], 15'h5A5A, 2'b01, a[17:3], 2'b10, 15'h0F0F};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every rdy_o is matched against the oldest expected hit word.
    always @(posedge clk) begin
        logic [63:0] w;
        #1;
        if (rdy_o) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rdy_unexpected: rdy_o=1 dat_o=%h, no read outstanding", dat_o);
            end else begin
                w = exp_q.pop_front();
                if (dat_o !== w) begin
                    n_fail++;
                    $display("FAIL rdy_data: dat_o=%h expected %h", dat_o, w);
                end
            end
        end
    end

    task automatic pulse_req(input logic [17:0] a, input bit hit, input bit inv);
        logic [17:0] base;
        base = {a[17:5], 5'd0};
        if (hit) begin
            exp_q.push_back(rom(a));
        end else begin
            for (int b = 0; b < 4; b++)
                bus_q.push_back('{adr: base + 18'(8 * b), cti: (b < 3) ? 3'b010 : 3'b111});
        end
        radr_i = a;
        req_i  = 1'b1;
        inv_i  = inv;
        tick();
        req_i  = 1'b0;
        inv_i  = 1'b0;
        n_tests++;
        if (cyc_o !== !hit) begin
            n_fail++;
            $display("FAIL req_bus_start: addr=%h cyc_o=%b expected %b", a, cyc_o, !hit);
        end
        if (!hit) begin
            n_tests++;
            if (adr_o !== base || cs_o !== 1'b1) begin
                n_fail++;
                $display("FAIL req_line_base: adr_o=%h cs_o=%b expected %h 1", adr_o, cs_o, base);
            end
        end
    endtask

    task automatic serve(input bit do_ack, input int inv_beat, output int n_beats,
                         output int n_cyc, output logic err_end, output logic cs_end,
                         output logic err_after);
        beat_t e;
        n_beats = 0;
        n_cyc   = 0;
        for (int k = 0; k < 400 && cyc_o; k++) begin
            n_cyc++;
            if (do_ack) begin
                n_tests++;
                if (bus_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_extra_beat: adr_o=%h with no beat expected", adr_o);
                end else begin
                    e = bus_q.pop_front();
                    if (adr_o !== e.adr || cti_o !== e.cti || stb_o !== 1'b1 || cs_o !== 1'b1) begin
                        n_fail++;
                        $display("FAIL bus_beat: adr_o=%h cti_o=%b stb=%b cs=%b expected %h %b 1 1",
                                 adr_o, cti_o, stb_o, cs_o, e.adr, e.cti);
                    end
                end
                ack_i = 1'b1;
                dat_i = rom(adr_o);
                inv_i = (n_beats == inv_beat);
                n_beats++;
            end
            tick();
            ack_i = 1'b0;
            inv_i = 1'b0;
        end
        n_tests++;
        if (cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_budget: cyc_o=%b still high after 400 cycles, expected 0", cyc_o);
        end
        err_end = err_o;
        cs_end  = cs_o;
        tick();
        err_after = err_o;
    endtask

    task automatic fill_ok(input logic [17:0] a, input int inv_beat);
        int nb, nc;
        logic ee, ce, ea;
        pulse_req(a, 1'b0, 1'b0);
        serve(1'b1, inv_beat, nb, nc, ee, ce, ea);
        n_tests++;
        if (nb != 4 || bus_q.size() != 0 || ce !== 1'b0 || ee !== 1'b0 || ea !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_done: beats=%0d left=%0d cs_end=%b err=%b/%b expected 4 0 0 0/0",
                     nb, bus_q.size(), ce, ee, ea);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b0; radr_i = '0; inv_i = 1'b0; ack_i = 1'b0; dat_i = '0;
        tick(); tick();
        n_tests++;
        if (rdy_o !== 1'b0 || dat_o !== 64'd0 || err_o !== 1'b0 || cs_o !== 1'b0 ||
            cyc_o !== 1'b0 || stb_o !== 1'b0 || cti_o !== 3'b000 || adr_o !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b dat=%h err=%b cs=%b cyc=%b stb=%b cti=%b adr=%h expected all 0",
                     rdy_o, dat_o, err_o, cs_o, cyc_o, stb_o, cti_o, adr_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        fill_ok(18'h00008, -1);
        pulse_req(18'h00008, 1'b1, 1'b0);
    endtask

    task automatic test_hit();
        pulse_req(18'h00018, 1'b1, 1'b0);
        tick();
        n_tests++;
        if (rdy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_single: rdy_o=%b one cycle after hit, expected 0", rdy_o);
        end
    endtask

    task automatic test_back_to_back();
        fill_ok(18'h00020, -1);
        pulse_req(18'h00028, 1'b1, 1'b0);
        fill_ok(18'h00008, -1);
        pulse_req(18'h00000, 1'b1, 1'b0);
    endtask

    task automatic test_inv_fetch();
        fill_ok(18'h00040, 1);
        fill_ok(18'h00040, -1);
        pulse_req(18'h00048, 1'b1, 1'b0);
    endtask

    task automatic test_inv_hit();
        pulse_req(18'h00050, 1'b1, 1'b1);
        fill_ok(18'h00058, -1);
        pulse_req(18'h00058, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int nb, nc;
        logic ee, ce, ea;
        pulse_req(18'h00100, 1'b0, 1'b0);
        bus_q.delete();
        serve(1'b0, -1, nb, nc, ee, ce, ea);
        n_tests++;
        if (nc != 255 || ee !== 1'b1 || ea !== 1'b0 || ce !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: cyc_cycles=%0d err=%b/%b cs=%b expected 255 1/0 0", nc, ee, ea, ce);
        end
        fill_ok(18'h00100, -1);
        pulse_req(18'h00110, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        pulse_req(18'h00200, 1'b0, 1'b0);
        for (int b = 0; b < 2; b++) begin
            void'(bus_q.pop_front());
            ack_i = 1'b1;
            dat_i = rom(adr_o);
            tick();
        end
        ack_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        n_tests++;
        if (cyc_o !== 1'b0 || cs_o !== 1'b0 || stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: cyc=%b cs=%b stb=%b before next edge, expected 0 0 0", cyc_o, cs_o, stb_o);
        end
        bus_q.delete();
        tick();
        rst_i = 1'b0;
        tick();
        fill_ok(18'h00208, -1);
        pulse_req(18'h00218, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hit();
        test_back_to_back();
        test_inv_fetch();
        test_inv_hit();
        test_timeout();
        test_reset_mid_burst();
        tick(); tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rdy_missing: %0d hit reads never returned, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
